// File: rtl/wb_pipe_if.sv
// wb_pipe_if: data-memory load handshake between the writeback pipe and memory.
// master = pipeline side (issues requests), slave = memory side (answers them).
interface wb_pipe_if;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (output dmem_req, output dmem_addr, input dmem_ready, input dmem_rdata);
  modport slave  (input dmem_req, input dmem_addr, output dmem_ready, output dmem_rdata);
endinterface

// File: rtl/wb_pipe.sv
// wb_pipe: EX/MEM and MEM/WB pipeline registers with a blocking load handshake
// and the GPR/CSR write ports.
// Optional feature: define WB_PERF_CNT_EN to add retire_cnt / stall_cnt outputs.
module wb_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_rw,
  input  logic        ex_csrr,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  ex_rs3,
  input  logic [1:0]  ex_wbsel,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_pc4,
  input  logic [31:0] ex_csr_old,
  input  logic        flush,
  wb_pipe_if.master   dmem,
  output logic [4:0]  ex_mem_rd,
  output logic [4:0]  ex_mem_rs3,
  output logic        ex_mem_rw,
  output logic        ex_mem_csrr,
  output logic [1:0]  ex_mem_wbsel,
  output logic [31:0] ex_mem_aluout,
  output logic [4:0]  mem_wb_rd,
  output logic [4:0]  mem_wb_rs3,
  output logic        mem_wb_rw,
  output logic        mem_wb_csrr,
  output logic [31:0] mem_wb_wd,
  output logic [31:0] mem_wb_csr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        csr_we,
  output logic [4:0]  csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        stall_req
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0] retire_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_CSR  = 2'b11;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;
  state_t state_reg, state_next;

  // EX/MEM: result_reg holds the selected result, alu_reg the raw ALU value
  // (load address / CSR new value).
  logic        em_valid_reg, em_rw_reg, em_csrr_reg;
  logic [4:0]  em_rd_reg, em_rs3_reg;
  logic [1:0]  em_wbsel_reg;
  logic [31:0] em_alu_reg, em_result_reg;
  logic [31:0] ex_result;

  logic        mw_rw_reg, mw_csrr_reg;
  logic [4:0]  mw_rd_reg, mw_rs3_reg;
  logic [31:0] mw_wd_reg, mw_csr_reg;

  logic        is_load;

  // Select the writeback value leaving EX; loads carry the address until MEM.
  always_comb begin
    ex_result = ex_aluout;
    case (ex_wbsel)
      WB_PC4:  ex_result = ex_pc4;
      WB_CSR:  ex_result = ex_csr_old;
      default: ex_result = ex_aluout;
    endcase
  end

  assign is_load        = em_valid_reg & (em_wbsel_reg == WB_LOAD);
  assign dmem.dmem_req  = is_load & ((state_reg == ST_RUN) | (state_reg == ST_WAIT));
  assign dmem.dmem_addr = em_alu_reg;
  assign stall_req      = dmem.dmem_req & ~dmem.dmem_ready;

  // Load-wait state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_RUN;
    else     state_reg <= state_next;
  end

  // Next state: enter WAIT on an unanswered request, leave it once memory answers.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (dmem.dmem_req & ~dmem.dmem_ready) state_next = ST_WAIT;
      ST_WAIT: if (dmem.dmem_ready) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // EX/MEM capture; frozen while the load stalls, so flush cannot touch the held entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      em_valid_reg  <= 1'b0;
      em_rw_reg     <= 1'b0;
      em_csrr_reg   <= 1'b0;
      em_rd_reg     <= 5'd0;
      em_rs3_reg    <= 5'd0;
      em_wbsel_reg  <= 2'd0;
      em_alu_reg    <= 32'd0;
      em_result_reg <= 32'd0;
    end else if (!stall_req) begin
      em_valid_reg  <= ex_valid & ~flush;
      em_rw_reg     <= ex_rw;
      em_csrr_reg   <= ex_csrr;
      em_rd_reg     <= ex_rd;
      em_rs3_reg    <= ex_rs3;
      em_wbsel_reg  <= ex_wbsel;
      em_alu_reg    <= ex_aluout;
      em_result_reg <= ex_result;
    end
  end

  assign ex_mem_rd     = em_rd_reg;
  assign ex_mem_rs3    = em_rs3_reg;
  assign ex_mem_rw     = em_valid_reg & em_rw_reg;
  assign ex_mem_csrr   = em_valid_reg & em_csrr_reg;
  assign ex_mem_wbsel  = em_wbsel_reg;
  assign ex_mem_aluout = em_result_reg;

  // MEM/WB: bubble while stalled, otherwise take EX/MEM with load data merged in.
  always_ff @(posedge clk) begin
    if (rst) begin
      mw_rw_reg   <= 1'b0;
      mw_csrr_reg <= 1'b0;
      mw_rd_reg   <= 5'd0;
      mw_rs3_reg  <= 5'd0;
      mw_wd_reg   <= 32'd0;
      mw_csr_reg  <= 32'd0;
    end else if (stall_req) begin
      mw_rw_reg   <= 1'b0;
      mw_csrr_reg <= 1'b0;
    end else begin
      mw_rw_reg   <= ex_mem_rw;
      mw_csrr_reg <= ex_mem_csrr;
      mw_rd_reg   <= em_rd_reg;
      mw_rs3_reg  <= em_rs3_reg;
      mw_wd_reg   <= (em_wbsel_reg == WB_LOAD) ? dmem.dmem_rdata : em_result_reg;
      mw_csr_reg  <= em_alu_reg;
    end
  end

  assign mem_wb_rd   = mw_rd_reg;
  assign mem_wb_rs3  = mw_rs3_reg;
  assign mem_wb_rw   = mw_rw_reg;
  assign mem_wb_csrr = mw_csrr_reg;
  assign mem_wb_wd   = mw_wd_reg;
  assign mem_wb_csr  = mw_csr_reg;

  // x0 is hardwired, so a write to it is dropped here.
  assign rf_we     = mw_rw_reg & (mw_rd_reg != 5'd0);
  assign rf_waddr  = mw_rd_reg;
  assign rf_wdata  = mw_wd_reg;
  assign csr_we    = mw_csrr_reg;
  assign csr_waddr = mw_rs3_reg;
  assign csr_wdata = mw_csr_reg;

`ifdef WB_PERF_CNT_EN
  logic        mw_valid_reg;
  logic [31:0] retire_cnt_reg, stall_cnt_reg;

  // MEM/WB valid bit, kept only for retirement counting.
  always_ff @(posedge clk) begin
    if (rst)            mw_valid_reg <= 1'b0;
    else if (stall_req) mw_valid_reg <= 1'b0;
    else                mw_valid_reg <= em_valid_reg;
  end

  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= 32'd0;
      stall_cnt_reg  <= 32'd0;
    end else begin
      if (mw_valid_reg) retire_cnt_reg <= retire_cnt_reg + 32'd1;
      if (stall_req)    stall_cnt_reg  <= stall_cnt_reg + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_reg;
  assign stall_cnt  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// tb_wb_pipe: directed stimulus for wb_pipe with an in-order writeback
// scoreboard and a behavioural memory that answers loads after a set delay.
module tb_wb_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ex_valid, ex_rw, ex_csrr, flush;
  logic [4:0]  ex_rd, ex_rs3;
  logic [1:0]  ex_wbsel;
  logic [31:0] ex_aluout, ex_pc4, ex_csr_old;
  logic [4:0]  ex_mem_rd, ex_mem_rs3, mem_wb_rd, mem_wb_rs3, rf_waddr, csr_waddr;
  logic        ex_mem_rw, ex_mem_csrr, mem_wb_rw, mem_wb_csrr, rf_we, csr_we, stall_req;
  logic [1:0]  ex_mem_wbsel;
  logic [31:0] ex_mem_aluout, mem_wb_wd, mem_wb_csr, rf_wdata, csr_wdata;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  wb_pipe_if bus ();

  wb_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_rw(ex_rw), .ex_csrr(ex_csrr),
    .ex_rd(ex_rd), .ex_rs3(ex_rs3), .ex_wbsel(ex_wbsel),
    .ex_aluout(ex_aluout), .ex_pc4(ex_pc4), .ex_csr_old(ex_csr_old),
    .flush(flush), .dmem(bus.master),
    .ex_mem_rd(ex_mem_rd), .ex_mem_rs3(ex_mem_rs3), .ex_mem_rw(ex_mem_rw),
    .ex_mem_csrr(ex_mem_csrr), .ex_mem_wbsel(ex_mem_wbsel), .ex_mem_aluout(ex_mem_aluout),
    .mem_wb_rd(mem_wb_rd), .mem_wb_rs3(mem_wb_rs3), .mem_wb_rw(mem_wb_rw),
    .mem_wb_csrr(mem_wb_csrr), .mem_wb_wd(mem_wb_wd), .mem_wb_csr(mem_wb_csr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .stall_req(stall_req)
`ifdef WB_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rf_en;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        csr_en;
    logic [4:0]  rs3;
    logic [31:0] csr;
  } wb_t;
  wb_t exp_q[$];

  int load_wait = 0;
  int exp_stall = 0;
  int obs_stall = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory: answers a request once it has been pending for load_wait cycles.
  logic last_req, last_ready;
  int   req_cnt = 0;
  initial begin
    bus.dmem_ready = 1'b1;
    bus.dmem_rdata = 32'd0;
  end
  always @(negedge clk) begin
    last_req   = (bus.dmem_req === 1'b1);
    last_ready = (bus.dmem_ready === 1'b1);
  end
  always begin
    @(posedge clk);
    #1;
    req_cnt = (last_req && !last_ready) ? req_cnt + 1 : 0;
    if (bus.dmem_req === 1'b1) begin
      bus.dmem_ready = (req_cnt >= load_wait);
      bus.dmem_rdata = mem_word(bus.dmem_addr);
    end else begin
      bus.dmem_ready = 1'b1;   // ready with no request must be ignored
      bus.dmem_rdata = 32'hFFFF_FFFF;
    end
  end

  // Scoreboard: every register-file / CSR write must match the next expected retirement.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (stall_req === 1'b1) obs_stall++;
      if (rf_we !== 1'b0 || csr_we !== 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", {30'd0, rf_we, csr_we}, 32'd0);
        end else begin
          wb_t e;
          e = exp_q.pop_front();
          chk("sb_rf_we", {31'd0, rf_we}, {31'd0, e.rf_en});
          if (e.rf_en) begin
            chk("sb_rf_waddr", {27'd0, rf_waddr}, {27'd0, e.rd});
            chk("sb_rf_wdata", rf_wdata, e.wd);
          end
          chk("sb_csr_we", {31'd0, csr_we}, {31'd0, e.csr_en});
          if (e.csr_en) begin
            chk("sb_csr_waddr", {27'd0, csr_waddr}, {27'd0, e.rs3});
            chk("sb_csr_wdata", csr_wdata, e.csr);
          end
          $display("retire rf_we=%0d rd=%0d wd=%h csr_we=%0d rs3=%0d csr=%h",
                   rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata);
        end
      end
    end
  end

  // Present one instruction (caller at a negedge); hold it until accepted,
  // then record what it must eventually write. Returns at the negedge after capture.
  task automatic issue(input logic v, input logic rw, input logic csrr,
                       input logic [4:0] rd, input logic [4:0] rs3, input logic [1:0] wbsel,
                       input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] cold,
                       input logic fl, input int lw);
    bit  acc = 0;
    wb_t e;
    ex_valid = v; ex_rw = rw; ex_csrr = csrr; ex_rd = rd; ex_rs3 = rs3;
    ex_wbsel = wbsel; ex_aluout = alu; ex_pc4 = pc4; ex_csr_old = cold; flush = fl;
    for (int i = 0; i < 40 && !acc; i++) begin
      acc = (stall_req !== 1'b1);
      if (acc) load_wait = lw;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
    if (!acc) chk("issue_timeout", 32'd1, 32'd0);
    if (acc && v && !fl) begin
      case (wbsel)
        2'b00:   e.wd = alu;
        2'b01:   e.wd = mem_word(alu);
        2'b10:   e.wd = pc4;
        default: e.wd = cold;
      endcase
      e.rf_en = rw && (rd != 5'd0);
      e.rd = rd; e.csr_en = csrr; e.rs3 = rs3; e.csr = alu;
      if (e.rf_en || e.csr_en) exp_q.push_back(e);
      if (wbsel == 2'b01) exp_stall += lw;
      $display("issue rd=%0d rs3=%0d wbsel=%0d alu=%h rw=%0d csrr=%0d", rd, rs3, wbsel, alu, rw, csrr);
    end
    @(negedge clk);
    ex_valid = 1'b0; ex_rw = 1'b0; ex_csrr = 1'b0; flush = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 0; ex_rw = 0; ex_csrr = 0; ex_rd = 0; ex_rs3 = 0; ex_wbsel = 0;
    ex_aluout = 0; ex_pc4 = 0; ex_csr_old = 0; flush = 0;
    tick(2);
    rst = 1'b0;
    chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_csr_we", {31'd0, csr_we}, 32'd0);
    chk("rst_ex_mem_aluout", ex_mem_aluout, 32'd0);
    chk("rst_mem_wb_wd", mem_wb_wd, 32'd0);

    // ADD x5 = 0x1234
    issue(1, 1, 0, 5'd5, 5'd0, 2'b00, 32'h1234, 32'h0, 32'h0, 0, 0);
    chk("add_ex_mem_aluout", ex_mem_aluout, 32'h1234);
    chk("add_ex_mem_rw", {31'd0, ex_mem_rw}, 32'd1);
    tick(1);
    chk("add_rf_we", {31'd0, rf_we}, 32'd1);
    chk("add_rf_waddr", {27'd0, rf_waddr}, 32'd5);
    chk("add_rf_wdata", rf_wdata, 32'h1234);

    // JAL x1, link 0x2004
    issue(1, 1, 0, 5'd1, 5'd0, 2'b10, 32'h0000_0080, 32'h2004, 32'h0, 0, 0);
    chk("jal_ex_mem_aluout", ex_mem_aluout, 32'h2004);
    tick(1);
    chk("jal_rf_wdata", rf_wdata, 32'h2004);
    chk("jal_rf_waddr", {27'd0, rf_waddr}, 32'd1);

    // write to x0 is dropped
    issue(1, 1, 0, 5'd0, 5'd0, 2'b00, 32'h55, 32'h0, 32'h0, 0, 0);
    tick(1);
    chk("x0_rf_we", {31'd0, rf_we}, 32'd0);

    // flushed CSR write never appears
    issue(1, 0, 1, 5'd0, 5'd3, 2'b11, 32'h77, 32'h0, 32'h9, 1, 0);
    chk("flush_ex_mem_csrr", {31'd0, ex_mem_csrr}, 32'd0);
    tick(1);
    chk("flush_csr_we", {31'd0, csr_we}, 32'd0);

    // CSRRW x9, csr 4: x9 <- old 0x77, csr <- 0xABCD
    issue(1, 1, 1, 5'd9, 5'd4, 2'b11, 32'hABCD, 32'h0, 32'h77, 0, 0);
    chk("csr_ex_mem_aluout", ex_mem_aluout, 32'h77);
    tick(1);
    chk("csr_csr_wdata", csr_wdata, 32'hABCD);
    chk("csr_rf_wdata", rf_wdata, 32'h77);

    // load x7 from 0x100 with two wait cycles
    issue(1, 1, 0, 5'd7, 5'd0, 2'b01, 32'h100, 32'h0, 32'h0, 0, 2);
    chk("ld_stall_c1", {31'd0, stall_req}, 32'd1);
    chk("ld_dmem_addr", bus.dmem_addr, 32'h100);
    tick(1);
    chk("ld_stall_c2", {31'd0, stall_req}, 32'd1);
    chk("ld_rf_we_during_stall", {31'd0, rf_we}, 32'd0);
    tick(1);
    chk("ld_stall_released", {31'd0, stall_req}, 32'd0);
    tick(1);
    chk("ld_rf_we", {31'd0, rf_we}, 32'd1);
    chk("ld_rf_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("ld_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
`ifdef WB_PERF_CNT_EN
    chk("ld_stall_cnt", stall_cnt, 32'd2);
`endif

    // zero-wait load: no stall, retires next cycle
    issue(1, 1, 0, 5'd12, 5'd0, 2'b01, 32'h200, 32'h0, 32'h0, 0, 0);
    chk("ld0_stall", {31'd0, stall_req}, 32'd0);
    tick(1);
    chk("ld0_rf_wdata", rf_wdata, 32'h5A5A_0200);

    // load followed back-to-back by an ADD held upstream during the stall
    issue(1, 1, 0, 5'd3, 5'd0, 2'b01, 32'h40, 32'h0, 32'h0, 0, 1);
    issue(1, 1, 0, 5'd4, 5'd0, 2'b00, 32'h99, 32'h0, 32'h0, 0, 0);
    tick(2);

    // flush asserted while a load is stalled does not kill the held load
    issue(1, 1, 0, 5'd6, 5'd0, 2'b01, 32'h80, 32'h0, 32'h0, 0, 2);
    flush = 1'b1;
    tick(3);
    flush = 1'b0;
    tick(2);
    chk("stall_cycles_total", obs_stall, exp_stall);

    // reset while waiting on memory
    issue(1, 1, 0, 5'd13, 5'd0, 2'b01, 32'h300, 32'h0, 32'h0, 0, 5);
    tick(1);
    chk("rw_stall_before", {31'd0, stall_req}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    chk("rw_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rw_dmem_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rw_ex_mem_rw", {31'd0, ex_mem_rw}, 32'd0);
    chk("rw_ex_mem_aluout", ex_mem_aluout, 32'd0);
    chk("rw_rf_we", {31'd0, rf_we}, 32'd0);
    rst = 1'b0;

    // pipeline resumes after reset
    issue(1, 1, 0, 5'd2, 5'd0, 2'b00, 32'hCAFE, 32'h0, 32'h0, 0, 0);
    tick(4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_pipe.md
WB_PIPE -- requirements
Module: wb_pipe

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL: ex_valid, ex_rw, ex_csrr  in  1 each  instruction valid, GPR write, CSR write leaving EX.
REQ-004 SHALL: ex_rd, ex_rs3  in  5 each  GPR destination, CSR index.
REQ-005 SHALL: ex_wbsel  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 CSR old value.
REQ-006 SHALL: ex_aluout, ex_pc4, ex_csr_old  in  32 each  EX results.
REQ-007 SHALL: flush  in  1  capture incoming EX instruction as bubble.
REQ-008 SHALL: dmem_req  out  1, dmem_addr  out  32; dmem_ready  in  1, dmem_rdata  in  32  load handshake.
REQ-009 SHALL: ex_mem_rd/ex_mem_rs3  out  5, ex_mem_rw/ex_mem_csrr  out  1, ex_mem_wbsel  out  2, ex_mem_aluout  out  32  forwarding-visible EX/MEM state.
REQ-010 SHALL: mem_wb_rd/mem_wb_rs3  out  5, mem_wb_rw/mem_wb_csrr  out  1, mem_wb_wd/mem_wb_csr  out  32  forwarding-visible MEM/WB state.
REQ-011 SHALL: rf_we  out  1, rf_waddr  out  5, rf_wdata  out  32  GPR write port.
REQ-012 SHALL: csr_we  out  1, csr_waddr  out  5, csr_wdata  out  32  CSR write port.
REQ-013 SHALL: stall_req  out  1  freeze IF/ID/EX.

Function
REQ-014 SHALL: EX/MEM captures ex_* when stall_req=0; valid bit = ex_valid & ~flush.
REQ-015 SHALL: ex_mem_rw = valid & captured rw; ex_mem_csrr = valid & captured csrr (bubbles never write or forward).
REQ-016 SHALL: ex_mem_aluout = captured aluout for wbsel 00, pc4 for 10, csr_old for 11, aluout for 01.
REQ-017 SHALL: dmem_req = EX/MEM valid & wbsel==01 & state RUN-or-WAIT; dmem_addr = captured aluout.
REQ-018 SHALL: FSM states RUN, WAIT; RUN->WAIT when dmem_req & ~dmem_ready; WAIT->RUN when dmem_ready; otherwise hold.
REQ-019 SHALL: stall_req = dmem_req & ~dmem_ready (combinational, valid in RUN and WAIT).
REQ-020 SHALL: while stall_req=1, EX/MEM holds, MEM/WB loads a bubble (rw=0, csrr=0).
REQ-021 SHALL: when stall_req=0, MEM/WB captures EX/MEM; mem_wb_wd = dmem_rdata for wbsel 01, else ex_mem_aluout; mem_wb_csr = captured aluout (CSR new value).
REQ-022 SHALL: latency: instruction in EX/MEM at edge N reaches MEM/WB at edge N+1 plus one cycle per wait cycle; ready in same cycle as request = zero wait.
REQ-023 SHALL: rf_we = mem_wb_rw & (mem_wb_rd!=0); rf_waddr = mem_wb_rd; rf_wdata = mem_wb_wd.
REQ-024 SHALL: csr_we = mem_wb_csrr; csr_waddr = mem_wb_rs3; csr_wdata = mem_wb_csr.
REQ-025 SHALL: flush during stall_req=1 is ignored for the held EX/MEM entry (upstream frozen).
REQ-026 SHALL: dmem_ready while no dmem_req is ignored.

Reset
REQ-027 SHALL: rst=1 at edge: state RUN, both stage valids 0, all rd/rs3/wbsel/data registers 0.
REQ-028 SHALL: after reset all outputs 0 (stall_req, dmem_req, rf_we, csr_we included); rst overrides stall and flush, including mid-WAIT.

Configuration
REQ-029 SHALL: macro WB_PERF_CNT_EN defined adds outputs retire_cnt (32) and stall_cnt (32): retire_cnt +1 per cycle MEM/WB holds a valid instruction, stall_cnt +1 per cycle stall_req=1, both wrap at 2^32, cleared by rst.
REQ-030 SHALL: WB_PERF_CNT_EN undefined: ports and counters absent, all other behaviour identical.

Verification
REQ-031 SHALL: ADD x5, aluout=0x1234, wbsel 00 at edge 1 -> ex_mem_aluout=0x1234 cycle 1, rf_we=1 waddr=5 wdata=0x1234 cycle 2.
REQ-032 SHALL: load x7 addr 0x100, dmem_ready low 2 cycles then high with rdata 0xDEADBEEF -> stall_req=1 for 2 cycles, state WAIT, then rf_wdata=0xDEADBEEF waddr=7; stall_cnt=2 if enabled.
REQ-033 SHALL: rw=1, rd=0, aluout=0x55 -> rf_we stays 0.
REQ-034 SHALL: flush=1 with valid CSR write rs3=3 -> ex_mem_csrr=0 and csr_we never asserts.
REQ-035 SHALL: rst asserted in WAIT -> next cycle stall_req=0, dmem_req=0, state RUN, all stage outputs 0.
REQ-036 SHALL: JAL x1, pc4=0x2004, wbsel 10 -> ex_mem_aluout=0x2004, rf_wdata=0x2004 waddr=1.
